// File: rtl/keypad_encoder.sv
// keypad_encoder
//
// Producer side of the cooking timer's digit-load interface. Debounces ten
// one-hot keypad lines, encodes a stable single-key press into a BCD digit
// and issues one single-cycle load strobe per press. It stops loading once
// MAX_DIGITS digits have been entered, until the next clear.
//
// Ports:
//   clk_i          - clock, all state changes on the rising edge
//   clear_i        - synchronous active-high reset, overrides everything
//   en_i           - key entry permitted (low while cooking)
//   keypad_i       - raw key lines, bit i high = key i pressed
//   data_out_o     - BCD code of the last accepted key
//   load_o         - single-cycle strobe, data_out_o valid in the same cycle
//   digit_count_o  - number of loads since the last clear (saturating)
//   full_o         - digit_count_o == MAX_DIGITS

module keypad_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,  // 1..255
    parameter int unsigned MAX_DIGITS      = 3   // 1..3
) (
    input  logic       clk_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [9:0] keypad_i,
    output logic [3:0] data_out_o,
    output logic       load_o,
    output logic [1:0] digit_count_o,
    output logic       full_o
);

    localparam logic [7:0] DbLimit  = DEBOUNCE_CYCLES[7:0];
    localparam logic [1:0] MaxCount = MAX_DIGITS[1:0];

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StWaitRelease
    } state_e;

    state_e     state_q;
    logic [9:0] pattern_q;
    logic [3:0] code_q;
    logic [7:0] cnt_q;
    logic [3:0] data_q;
    logic       load_q;
    logic [1:0] count_q;

    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] cnt_inc;

    // Exactly one line high; zero or several lines count as no key.
    assign key_valid = (keypad_i != '0) && ((keypad_i & (keypad_i - 10'd1)) == '0);
    assign cnt_inc   = cnt_q + 8'd1;

    // Only meaningful when key_valid, so a priority scan is enough.
    always_comb begin
        key_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad_i[i]) begin
                key_code = 4'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            load_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en_i && key_valid) begin
                        pattern_q <= keypad_i;
                        code_q    <= key_code;
                        cnt_q     <= '0;
                        state_q   <= StDebounce;
                    end
                end
                StDebounce: begin
                    if (!en_i || (keypad_i != pattern_q)) begin
                        // Any bounce or loss of enable restarts the whole press.
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else if (cnt_inc == DbLimit) begin
                        cnt_q   <= '0;
                        state_q <= StWaitRelease;
                        if (!full_o) begin
                            data_q  <= code_q;
                            load_q  <= 1'b1;
                            count_q <= count_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StWaitRelease: begin
                    // en_i ignored here; a bounce only restarts the release count.
                    if (keypad_i != '0) begin
                        cnt_q <= '0;
                    end else if (cnt_inc == DbLimit) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_out_o    = data_q;
    assign load_o        = load_q;
    assign digit_count_o = count_q;
    assign full_o        = (count_q == MaxCount);

endmodule
